mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Parametrised multicycle CPU control FSM, next generation of the byte-fetch MIPS-subset controller. Sits beside the datapath and drives its mux selects, ALU op class, register and memory enables, and instruction-register byte enables.
- Generalises the fetch-beat count. Adds a memory-ready stall handshake, BNE, ADDI and illegal-opcode detection.

Parameters:
- FETCH_BEATS, 4: number of memory beats needed to assemble one instruction; legal range 1..4. Sets the irwrite width.
- BEAT_W, (FETCH_BEATS>1 ? $clog2(FETCH_BEATS) : 1): width of the fetch-beat counter. Derived; not overridden.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  opcode field from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- iord  out  1  address select: 0 = PC, 1 = ALU result register.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = reg B, 01 = constant 1, 10 = immediate, 11 = branch offset.
- aluop  out  2  ALU class: 00 = add, 01 = subtract, 10 = funct-decoded.
- pcsource  out  2  PC source: 00 = ALU, 01 = ALU result register, 10 = jump target.
- pcen  out  1  PC write enable.
- regwrite  out  1  register file write enable.
- regdst  out  1  destination select: 1 = rd, 0 = rt.
- memtoreg  out  1  write-back select: 1 = memory data, 0 = ALU result register.
- irwrite  out  FETCH_BEATS  one-hot instruction-register byte enable.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.

Behaviour:
- Reset: synchronous, active-high. Next state = FETCH, beat counter = 0. While reset is high, every output is forced to 0, including irwrite, pcsource, alusrcb and aluop.
- Outputs are combinational from the registered state, beat counter, mem_ready and zero. No output is registered.
- Opcodes: LB 100000, SB 101000, RTYPE 000000, BEQ 000100, BNE 000101, ADDI 001000, J 000010.
- Outputs not listed for a state are 0.
- FETCH:
  - Drives memread=1, alusrcb=01.
  - When mem_ready=1: irwrite[beat]=1 and pcen=1 (PC+1).
  - When mem_ready=0: state and beat hold, pcen=0, irwrite=0.
  - On a ready beat: if beat==FETCH_BEATS-1, go to DECODE and reset beat to 0; otherwise beat++.
- DECODE:
  - Drives alusrcb=11.
  - Next state: LB/SB -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; BNE -> BNEEX; ADDI -> ADDIEX; J -> JEX.
  - Any other opcode: illegal_op=1 for this cycle, then FETCH.
- MEMADR: alusrca=1, alusrcb=10. Next state: LB -> LBRD, SB -> SBWR.
- LBRD: memread=1, iord=1. Holds until mem_ready=1, then LBWR.
- LBWR: regwrite=1, memtoreg=1. Next state FETCH.
- SBWR: memwrite=1, iord=1. Holds until mem_ready=1, then FETCH.
- RTYPEEX: alusrca=1, aluop=10. Next state RTYPEWR.
- RTYPEWR: regwrite=1, regdst=1. Next state FETCH.
- BEQEX: alusrca=1, aluop=01, pcsource=01, pcen=zero. Next state FETCH.
- BNEEX: same as BEQEX but pcen=~zero. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10. Next state ADDIWR.
- ADDIWR: regwrite=1, regdst=0, memtoreg=0. Next state FETCH.
- JEX: pcsource=10, pcen=1. Next state FETCH.
- Latency with mem_ready tied high, F = FETCH_BEATS:
  - J, BEQ, BNE: F+2 cycles.
  - RTYPE, ADDI, SB: F+3 cycles.
  - LB: F+4 cycles.
  - Each cycle with mem_ready=0 in FETCH, LBRD or SBWR adds one cycle.
- mem_ready is ignored in non-memory states.
- op is sampled only in DECODE and MEMADR; its value in other states has no effect.
- Reset in any state, including mid-stall or mid-fetch: next cycle is FETCH beat 0. A partially fetched instruction is discarded; no pcen or irwrite pulse occurs in the reset cycle.
- Unused state encodings recover to FETCH on the next edge.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (FETCH, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, BNEEX, ADDIEX, ADDIWR, JEX);
  - opcode localparams;
  - alusrcb, aluop and pcsource encoding constants.
- One sub-module, mc_fetch_seq: beat counter plus irwrite one-hot decode, with a done output to the main FSM. Everything else is a single state register plus combinational output and next-state logic.

Test Plan:
- FETCH_BEATS=4, mem_ready=1, op=000000 after reset:
  - irwrite goes 0001, 0010, 0100, 1000 on cycles 0-3, with pcen=1 each cycle.
  - DECODE then drives alusrcb=11.
  - RTYPEEX then drives aluop=10, alusrca=1.
  - RTYPEWR then drives regwrite=1, regdst=1.
  - Back in FETCH at cycle 7.
- FETCH_BEATS=2, op=100000, mem_ready low for 3 cycles in beat 1 and 2 cycles in LBRD:
  - irwrite=10 asserts only on the ready cycle.
  - LBWR drives regwrite=1, memtoreg=1.
  - Total 11 cycles.
- op=000100 with zero=1, then op=000101 with zero=1:
  - BEQ gives pcen=1, pcsource=01.
  - BNE gives pcen=0; BNE with zero=0 gives pcen=1.
- op=111111 at DECODE: illegal_op=1 for exactly one cycle, next state FETCH beat 0, no regwrite/memwrite/pcen in that cycle.
- Reset asserted during beat 2 of fetch and again during an SBWR stall:
  - All outputs are 0 while reset is high.
  - First post-reset cycle is FETCH with memread=1 and irwrite idle until mem_ready.
- op=001000 and op=000010, FETCH_BEATS=1:
  - ADDI: ADDIEX (alusrcb=10), then ADDIWR (regwrite=1, regdst=0); 4 cycles total.
  - J: JEX gives pcen=1, pcsource=10; 3 cycles total.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle CPU controller: FSM states, opcodes
// and the datapath select encodings driven by the controller.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        LBRD    = 4'd3,
        LBWR    = 4'd4,
        SBWR    = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWR = 4'd7,
        BEQEX   = 4'd8,
        BNEEX   = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWR  = 4'd11,
        JEX     = 4'd12
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] opc);
        return opc inside {OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    endfunction

endpackage

// File: rtl/mc_fetch_seq.sv
// Fetch-beat sequencer: counts memory beats of an instruction fetch and
// produces the one-hot instruction-register byte enable for each ready beat.
module mc_fetch_seq #(
    parameter int FETCH_BEATS = 4,
    parameter int BEAT_W      = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_active,
    input  logic                   i_ready,
    output logic [FETCH_BEATS-1:0] o_irwrite,
    output logic                   o_done
);

    logic [BEAT_W-1:0] r_beat;
    logic              w_step;
    logic              w_last;

    // A beat only advances when memory delivers; reset discards a partial fetch.
    assign w_step = i_active & i_ready & ~reset;
    assign w_last = (r_beat == BEAT_W'(FETCH_BEATS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat <= '0;
        end else if (w_step) begin
            r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
        end
    end

    assign o_irwrite = w_step ? (FETCH_BEATS'(1) << r_beat) : '0;
    assign o_done    = w_step & w_last;

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM with multi-beat instruction fetch,
// memory-ready stalls and illegal-opcode reporting; all outputs are Moore/Mealy comb.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int FETCH_BEATS = 4,
    parameter int BEAT_W      = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             op,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   memread,
    output logic                   memwrite,
    output logic                   iord,
    output logic                   alusrca,
    output logic [1:0]             alusrcb,
    output logic [1:0]             aluop,
    output logic [1:0]             pcsource,
    output logic                   pcen,
    output logic                   regwrite,
    output logic                   regdst,
    output logic                   memtoreg,
    output logic [FETCH_BEATS-1:0] irwrite,
    output logic                   illegal_op
);

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_fetch_done;
    logic [FETCH_BEATS-1:0] w_irwrite;

    mc_fetch_seq #(
        .FETCH_BEATS (FETCH_BEATS),
        .BEAT_W      (BEAT_W)
    ) u_fetch_seq (
        .clk       (clk),
        .reset     (reset),
        .i_active  (r_state == FETCH),
        .i_ready   (mem_ready),
        .o_irwrite (w_irwrite),
        .o_done    (w_fetch_done)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next;
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = w_fetch_done ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: w_next = MEMADR;
                    OP_RTYPE:     w_next = RTYPEEX;
                    OP_BEQ:       w_next = BEQEX;
                    OP_BNE:       w_next = BNEEX;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JEX;
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LB)      w_next = LBRD;
                else if (op == OP_SB) w_next = SBWR;
                else                  w_next = FETCH;
            end
            LBRD:    w_next = mem_ready ? LBWR : LBRD;
            SBWR:    w_next = mem_ready ? FETCH : SBWR;
            RTYPEEX: w_next = RTYPEWR;
            ADDIEX:  w_next = ADDIWR;
            // Unused encodings and all terminal states fall through to FETCH.
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        aluop      = ALUOP_ADD;
        pcsource   = PCSRC_ALU;
        pcen       = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        illegal_op = 1'b0;
        if (!reset) begin
            case (r_state)
                FETCH: begin
                    memread = 1'b1;
                    alusrcb = SRCB_ONE;
                    pcen    = mem_ready;
                end
                DECODE: begin
                    alusrcb    = SRCB_BOFF;
                    illegal_op = ~is_legal_op(op);
                end
                MEMADR, ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                LBRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                LBWR: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                SBWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                RTYPEWR: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                BEQEX, BNEEX: begin
                    alusrca  = 1'b1;
                    aluop    = ALUOP_SUB;
                    pcsource = PCSRC_ALUOUT;
                    pcen     = (r_state == BEQEX) ? zero : ~zero;
                end
                ADDIWR:  regwrite = 1'b1;
                JEX: begin
                    pcsource = PCSRC_JUMP;
                    pcen     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign irwrite = reset ? '0 : w_irwrite;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: three instances (FETCH_BEATS 4, 2, 1)
// share stimulus; each step compares one instance against hand-derived outputs.
module tb_mc_controller;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       illegal_op;
    } ctrl_t;

    //                                 rd  wr  io  sa  srcb   aluop  pcsrc  pce rw  rd  m2r ill
    localparam ctrl_t C_ZERO    = '{1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam ctrl_t C_FRDY    = '{1'b1,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0};
    localparam ctrl_t C_FSTALL  = '{1'b1,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam ctrl_t C_DECODE  = '{1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam ctrl_t C_DEC_ILL = '{1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1};
    localparam ctrl_t C_ADRIMM  = '{1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam ctrl_t C_LBRD    = '{1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam ctrl_t C_LBWR    = '{1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0};
    localparam ctrl_t C_SBWR    = '{1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam ctrl_t C_RTEX    = '{1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam ctrl_t C_RTWR    = '{1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0};
    localparam ctrl_t C_BR_TK   = '{1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0,1'b0,1'b0,1'b0};
    localparam ctrl_t C_BR_NT   = '{1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam ctrl_t C_ADDIWR  = '{1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0};
    localparam ctrl_t C_JEX     = '{1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0,1'b0,1'b0,1'b0};

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;

    wire [14:0] c4, c2, c1;
    wire [3:0]  irw4;
    wire [1:0]  irw2;
    wire [0:0]  irw1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_controller #(.FETCH_BEATS(4)) u4 (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .memread(c4[14]), .memwrite(c4[13]), .iord(c4[12]), .alusrca(c4[11]),
        .alusrcb(c4[10:9]), .aluop(c4[8:7]), .pcsource(c4[6:5]), .pcen(c4[4]),
        .regwrite(c4[3]), .regdst(c4[2]), .memtoreg(c4[1]), .irwrite(irw4),
        .illegal_op(c4[0])
    );

    mc_controller #(.FETCH_BEATS(2)) u2 (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .memread(c2[14]), .memwrite(c2[13]), .iord(c2[12]), .alusrca(c2[11]),
        .alusrcb(c2[10:9]), .aluop(c2[8:7]), .pcsource(c2[6:5]), .pcen(c2[4]),
        .regwrite(c2[3]), .regdst(c2[2]), .memtoreg(c2[1]), .irwrite(irw2),
        .illegal_op(c2[0])
    );

    mc_controller #(.FETCH_BEATS(1)) u1 (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .memread(c1[14]), .memwrite(c1[13]), .iord(c1[12]), .alusrca(c1[11]),
        .alusrcb(c1[10:9]), .aluop(c1[8:7]), .pcsource(c1[6:5]), .pcen(c1[4]),
        .regwrite(c1[3]), .regdst(c1[2]), .memtoreg(c1[1]), .irwrite(irw1),
        .illegal_op(c1[0])
    );

    task automatic chk(input string tag, input ctrl_t got, input logic [3:0] got_irw,
                       input ctrl_t exp, input logic [3:0] exp_irw);
        total++;
        assert ({got, got_irw} === {exp, exp_irw}) else begin
            bad++;
            $error("FAIL %s: observed ctrl=%h irwrite=%b, expected ctrl=%h irwrite=%b",
                   tag, got, got_irw, exp, exp_irw);
        end
    endtask

    task automatic chk4(input string tag, input ctrl_t exp, input logic [3:0] exp_irw);
        chk(tag, ctrl_t'(c4), irw4, exp, exp_irw);
    endtask

    task automatic chk2(input string tag, input ctrl_t exp, input logic [1:0] exp_irw);
        chk(tag, ctrl_t'(c2), {2'b00, irw2}, exp, {2'b00, exp_irw});
    endtask

    task automatic chk1(input string tag, input ctrl_t exp, input logic exp_irw);
        chk(tag, ctrl_t'(c1), {3'b000, irw1}, exp, {3'b000, exp_irw});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds reset over one edge and confirms every instance is silent meanwhile.
    task automatic do_reset;
        reset = 1'b1;
        tick();
        chk4("rst_u4", C_ZERO, 4'b0000);
        chk2("rst_u2", C_ZERO, 2'b00);
        chk1("rst_u1", C_ZERO, 1'b0);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 6'b000000; zero = 1'b0; mem_ready = 1'b1;

        // RTYPE, four beats, no stalls
        do_reset();
        chk4("rt_beat0", C_FRDY, 4'b0001);
        tick(); chk4("rt_beat1", C_FRDY, 4'b0010);
        tick(); chk4("rt_beat2", C_FRDY, 4'b0100);
        tick(); chk4("rt_beat3", C_FRDY, 4'b1000);
        tick(); chk4("rt_decode", C_DECODE, 4'b0000);
        tick(); chk4("rt_ex", C_RTEX, 4'b0000);
        tick(); chk4("rt_wr", C_RTWR, 4'b0000);
        tick(); chk4("rt_cycle7_fetch", C_FRDY, 4'b0001);

        // LB on the two-beat instance with fetch and read stalls: 11 cycles
        op = 6'b100000;
        do_reset();
        chk2("lb_beat0", C_FRDY, 2'b01);
        tick(); mem_ready = 1'b0; #1;
        chk2("lb_stall1", C_FSTALL, 2'b00);
        tick(); chk2("lb_stall2", C_FSTALL, 2'b00);
        tick(); chk2("lb_stall3", C_FSTALL, 2'b00);
        tick(); mem_ready = 1'b1; #1;
        chk2("lb_beat1", C_FRDY, 2'b10);
        tick(); chk2("lb_decode", C_DECODE, 2'b00);
        tick(); chk2("lb_memadr", C_ADRIMM, 2'b00);
        tick(); mem_ready = 1'b0; #1;
        chk2("lb_rd_stall1", C_LBRD, 2'b00);
        tick(); chk2("lb_rd_stall2", C_LBRD, 2'b00);
        tick(); mem_ready = 1'b1; #1;
        chk2("lb_rd_ready", C_LBRD, 2'b00);
        tick(); chk2("lb_wr", C_LBWR, 2'b00);
        tick(); chk2("lb_cycle11_fetch", C_FRDY, 2'b01);

        // Branches on the single-beat instance
        op = 6'b000100; zero = 1'b1;
        do_reset();
        chk1("beq_fetch", C_FRDY, 1'b1);
        tick(); chk1("beq_decode", C_DECODE, 1'b0);
        tick(); chk1("beq_taken", C_BR_TK, 1'b0);
        zero = 1'b0; #1;
        chk1("beq_not_taken", C_BR_NT, 1'b0);
        tick(); op = 6'b000101; zero = 1'b1; #1;
        chk1("bne_fetch", C_FRDY, 1'b1);
        tick(); chk1("bne_decode", C_DECODE, 1'b0);
        tick(); chk1("bne_zero1", C_BR_NT, 1'b0);
        zero = 1'b0; #1;
        chk1("bne_zero0", C_BR_TK, 1'b0);

        // Illegal opcode pulses for one cycle and returns to fetch
        tick(); op = 6'b111111; #1;
        chk1("ill_fetch", C_FRDY, 1'b1);
        tick(); chk1("ill_decode", C_DEC_ILL, 1'b0);
        tick(); chk1("ill_back_fetch", C_FRDY, 1'b1);

        // ADDI (4 cycles), J (3 cycles), SB (4 cycles) back to back
        op = 6'b001000;
        tick(); chk1("addi_decode", C_DECODE, 1'b0);
        tick(); chk1("addi_ex", C_ADRIMM, 1'b0);
        tick(); chk1("addi_wr", C_ADDIWR, 1'b0);
        tick(); op = 6'b000010; #1;
        chk1("j_fetch", C_FRDY, 1'b1);
        tick(); chk1("j_decode", C_DECODE, 1'b0);
        tick(); chk1("j_ex", C_JEX, 1'b0);
        tick(); op = 6'b101000; #1;
        chk1("sb_fetch", C_FRDY, 1'b1);
        tick(); chk1("sb_decode", C_DECODE, 1'b0);
        tick(); chk1("sb_memadr", C_ADRIMM, 1'b0);
        tick(); chk1("sb_wr", C_SBWR, 1'b0);
        tick(); chk1("sb_back_fetch", C_FRDY, 1'b1);

        // Reset mid-fetch on the four-beat instance discards the partial fetch
        op = 6'b000000; mem_ready = 1'b1;
        do_reset();
        tick();
        tick(); reset = 1'b1; #1;
        chk4("rst_midfetch_quiet", C_ZERO, 4'b0000);
        tick(); reset = 1'b0; mem_ready = 1'b0; #1;
        chk4("rst_midfetch_stall", C_FSTALL, 4'b0000);
        mem_ready = 1'b1; #1;
        chk4("rst_midfetch_beat0", C_FRDY, 4'b0001);

        // Reset during an SBWR stall
        op = 6'b101000;
        tick(); tick(); tick();
        tick(); chk4("sbst_decode", C_DECODE, 4'b0000);
        tick(); chk4("sbst_memadr", C_ADRIMM, 4'b0000);
        tick(); mem_ready = 1'b0; #1;
        chk4("sbst_wr_stall", C_SBWR, 4'b0000);
        tick(); chk4("sbst_wr_hold", C_SBWR, 4'b0000);
        reset = 1'b1; #1;
        chk4("sbst_rst_quiet", C_ZERO, 4'b0000);
        tick(); reset = 1'b0; #1;
        chk4("sbst_post_stall", C_FSTALL, 4'b0000);
        mem_ready = 1'b1; #1;
        chk4("sbst_post_beat0", C_FRDY, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
